// File: rtl/fs_score_pipe.sv
// FAST corner-score pipeline: classify circle points, detect a contiguous arc, score,
// and emit a back-pressured write request to the score memory.
module fs_score_pipe #(
    parameter int PIX_W      = 8,
    parameter int NPTS       = 16,
    parameter int ARC_LEN    = 9,
    parameter int ADDR_W     = 15,
    parameter int SCORE_W    = 8,
    parameter int CNT_W      = 16,
    parameter bit WRITE_ZERO = 1'b0
) (
    input  logic                    clock,
    input  logic                    nReset,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [ADDR_W-1:0]       refAddr,
    input  logic [PIX_W-1:0]        refPixel,
    input  logic [NPTS*PIX_W-1:0]   adjPixel,
    input  logic [PIX_W-1:0]        thres,
    output logic                    wren,
    input  logic                    outReady,
    output logic [ADDR_W-1:0]       refScoreAddr,
    output logic [SCORE_W-1:0]      scoreValue,
    output logic                    isCorner,
    input  logic                    frameStart,
    output logic [CNT_W-1:0]        cornerCount
);

    localparam int ACC_W = PIX_W + $clog2(NPTS);
    localparam int EXT_W = PIX_W + 1;

    // valid/ready: a sample moves in on a clock edge where inValid && inReady; a write
    // leaves on an edge where wren && outReady. Every stage holds while advance is low.
    logic advance;
    assign advance = !wren || outReady;
    assign inReady = advance;

    logic                  s1_valid;
    logic [NPTS-1:0]       s1_bright;
    logic [NPTS-1:0]       s1_dark;
    logic [NPTS*PIX_W-1:0] s1_e;
    logic [NPTS*PIX_W-1:0] s1_d;
    logic [ADDR_W-1:0]     s1_addr;

    logic                  s2_valid;
    logic                  s2_arc;
    logic [ACC_W-1:0]      s2_sb;
    logic [ACC_W-1:0]      s2_sd;
    logic [ADDR_W-1:0]     s2_addr;

    // Stage 1 combinational: classification and excesses in PIX_W+1 bits so nothing wraps.
    logic [NPTS-1:0]       c_bright;
    logic [NPTS-1:0]       c_dark;
    logic [NPTS*PIX_W-1:0] c_e;
    logic [NPTS*PIX_W-1:0] c_d;
    logic [EXT_W-1:0]      c_hi;
    logic [EXT_W-1:0]      c_ref;
    logic [EXT_W-1:0]      c_adj;
    logic [EXT_W-1:0]      c_lo;
    logic [EXT_W-1:0]      c_be;
    logic [EXT_W-1:0]      c_de;

    always_comb begin
        c_bright = '0;
        c_dark   = '0;
        c_e      = '0;
        c_d      = '0;
        c_ref    = {1'b0, refPixel};
        c_hi     = c_ref + {1'b0, thres};
        c_adj    = '0;
        c_lo     = '0;
        c_be     = '0;
        c_de     = '0;
        for (int i = 0; i < NPTS; i++) begin
            c_adj = {1'b0, adjPixel[i*PIX_W +: PIX_W]};
            c_lo  = c_adj + {1'b0, thres};
            c_be  = c_adj - c_hi;
            c_de  = c_ref - c_lo;
            if (c_adj > c_hi) begin
                c_bright[i]            = 1'b1;
                c_e[i*PIX_W +: PIX_W]  = c_be[PIX_W-1:0];
            end
            if (c_lo < c_ref) begin
                c_dark[i]              = 1'b1;
                c_d[i*PIX_W +: PIX_W]  = c_de[PIX_W-1:0];
            end
        end
    end

    // Stage 2 combinational: circular run search and excess sums.
    logic             arc_b;
    logic             arc_d;
    logic             run_b;
    logic             run_d;
    logic [ACC_W-1:0] sum_b;
    logic [ACC_W-1:0] sum_d;

    always_comb begin
        arc_b = 1'b0;
        arc_d = 1'b0;
        run_b = 1'b0;
        run_d = 1'b0;
        for (int s = 0; s < NPTS; s++) begin
            run_b = 1'b1;
            run_d = 1'b1;
            for (int k = 0; k < ARC_LEN; k++) begin
                run_b = run_b & s1_bright[(s + k) % NPTS];
                run_d = run_d & s1_dark[(s + k) % NPTS];
            end
            arc_b = arc_b | run_b;
            arc_d = arc_d | run_d;
        end
    end

    always_comb begin
        sum_b = '0;
        sum_d = '0;
        for (int i = 0; i < NPTS; i++) begin
            sum_b = sum_b + ACC_W'(s1_e[i*PIX_W +: PIX_W]);
            sum_d = sum_d + ACC_W'(s1_d[i*PIX_W +: PIX_W]);
        end
    end

    // Stage 3 combinational: pick the larger sum and clamp to the score width.
    logic [ACC_W-1:0]   raw;
    logic [SCORE_W-1:0] sat_score;
    assign raw = (s2_sb > s2_sd) ? s2_sb : s2_sd;

    generate
        if (ACC_W > SCORE_W) begin : g_sat
            assign sat_score = (|raw[ACC_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : raw[SCORE_W-1:0];
        end else begin : g_nosat
            assign sat_score = SCORE_W'(raw);
        end
    endgenerate

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            s1_valid     <= 1'b0;
            s1_bright    <= '0;
            s1_dark      <= '0;
            s1_e         <= '0;
            s1_d         <= '0;
            s1_addr      <= '0;
            s2_valid     <= 1'b0;
            s2_arc       <= 1'b0;
            s2_sb        <= '0;
            s2_sd        <= '0;
            s2_addr      <= '0;
            wren         <= 1'b0;
            refScoreAddr <= '0;
            scoreValue   <= '0;
            isCorner     <= 1'b0;
        end else if (advance) begin
            s1_valid     <= inValid;
            s1_bright    <= c_bright;
            s1_dark      <= c_dark;
            s1_e         <= c_e;
            s1_d         <= c_d;
            s1_addr      <= refAddr;
            s2_valid     <= s1_valid;
            s2_arc       <= arc_b | arc_d;
            s2_sb        <= sum_b;
            s2_sd        <= sum_d;
            s2_addr      <= s1_addr;
            // Non-corners become bubbles unless zero-score writes are wanted.
            wren         <= s2_valid && (s2_arc || WRITE_ZERO);
            refScoreAddr <= s2_addr;
            scoreValue   <= s2_arc ? sat_score : '0;
            isCorner     <= s2_valid && s2_arc;
        end
    end

    logic corner_done;
    assign corner_done = wren && outReady && isCorner;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            cornerCount <= '0;
        end else if (frameStart) begin
            cornerCount <= corner_done ? CNT_W'(1) : '0;
        end else if (corner_done && (cornerCount != {CNT_W{1'b1}})) begin
            cornerCount <= cornerCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_fs_score_pipe.sv
// Directed bench for fs_score_pipe: one instance without and one with zero-score writes,
// sharing all inputs; expected values are hand-computed from the corner/score rules.
module tb_fs_score_pipe;

    localparam int PIX_W   = 8;
    localparam int NPTS    = 16;
    localparam int ADDR_W  = 15;
    localparam int SCORE_W = 8;
    localparam int CNT_W   = 16;

    logic                  clock;
    logic                  nReset;
    logic                  inValid;
    logic [ADDR_W-1:0]     refAddr;
    logic [PIX_W-1:0]      refPixel;
    logic [NPTS*PIX_W-1:0] adjPixel;
    logic [PIX_W-1:0]      thres;
    logic                  outReady;
    logic                  frameStart;

    logic                  inReady,  inReady_z;
    logic                  wren,     wren_z;
    logic [ADDR_W-1:0]     refScoreAddr, refScoreAddr_z;
    logic [SCORE_W-1:0]    scoreValue, scoreValue_z;
    logic                  isCorner, isCorner_z;
    logic [CNT_W-1:0]      cornerCount, cornerCount_z;

    int n_vec = 0;
    int n_err = 0;

    logic [ADDR_W+SCORE_W-1:0] exp_q[$];

    fs_score_pipe #(.PIX_W(PIX_W), .NPTS(NPTS), .ARC_LEN(9), .ADDR_W(ADDR_W),
                    .SCORE_W(SCORE_W), .CNT_W(CNT_W), .WRITE_ZERO(1'b0)) dut (
        .clock(clock), .nReset(nReset), .inValid(inValid), .inReady(inReady),
        .refAddr(refAddr), .refPixel(refPixel), .adjPixel(adjPixel), .thres(thres),
        .wren(wren), .outReady(outReady), .refScoreAddr(refScoreAddr),
        .scoreValue(scoreValue), .isCorner(isCorner), .frameStart(frameStart),
        .cornerCount(cornerCount)
    );

    fs_score_pipe #(.PIX_W(PIX_W), .NPTS(NPTS), .ARC_LEN(9), .ADDR_W(ADDR_W),
                    .SCORE_W(SCORE_W), .CNT_W(CNT_W), .WRITE_ZERO(1'b1)) dut_wz (
        .clock(clock), .nReset(nReset), .inValid(inValid), .inReady(inReady_z),
        .refAddr(refAddr), .refPixel(refPixel), .adjPixel(adjPixel), .thres(thres),
        .wren(wren_z), .outReady(outReady), .refScoreAddr(refScoreAddr_z),
        .scoreValue(scoreValue_z), .isCorner(isCorner_z), .frameStart(frameStart),
        .cornerCount(cornerCount_z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [NPTS*PIX_W-1:0] pat(input logic [NPTS-1:0] mask,
                                                  input logic [PIX_W-1:0] on_v,
                                                  input logic [PIX_W-1:0] off_v);
        logic [NPTS*PIX_W-1:0] v;
        v = '0;
        for (int i = 0; i < NPTS; i++) v[i*PIX_W +: PIX_W] = mask[i] ? on_v : off_v;
        return v;
    endfunction

    task automatic drive(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] r,
                         input logic [PIX_W-1:0] t, input logic [NPTS*PIX_W-1:0] adj);
        inValid  = 1'b1;
        refAddr  = a;
        refPixel = r;
        thres    = t;
        adjPixel = adj;
    endtask

    // Drive one sample at a negedge and return at the negedge where it sits in S3.
    task automatic run_one(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] r,
                           input logic [PIX_W-1:0] t, input logic [NPTS*PIX_W-1:0] adj);
        drive(a, r, t, adj);
        @(negedge clock);
        inValid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        n_vec++; if (wren !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %0b want 0", wren); end
        n_vec++; if (scoreValue !== '0) begin n_err++; $display("FAIL reset_score: got %0h want 0", scoreValue); end
        n_vec++; if (cornerCount !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cornerCount); end
        nReset = 1'b1;
        @(negedge clock);
        n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL reset_inready: got %0b want 1", inReady); end
    endtask

    task automatic test_bright;
        drive(15'h1234, 8'd100, 8'd20, pat(16'h01FF, 8'd130, 8'd100));
        @(negedge clock);
        inValid = 1'b0;
        thres   = 8'd0;
        refAddr = 15'h0000;
        n_vec++; if (wren !== 1'b0) begin n_err++; $display("FAIL bright_lat_e0: wren got %0b want 0", wren); end
        @(negedge clock);
        n_vec++; if (wren !== 1'b0) begin n_err++; $display("FAIL bright_lat_e1: wren got %0b want 0", wren); end
        @(negedge clock);
        n_vec++; if (wren !== 1'b1) begin n_err++; $display("FAIL bright_wren: got %0b want 1", wren); end
        n_vec++; if (scoreValue !== 8'h5A) begin n_err++; $display("FAIL bright_score: got %0h want 5a", scoreValue); end
        n_vec++; if (isCorner !== 1'b1) begin n_err++; $display("FAIL bright_corner: got %0b want 1", isCorner); end
        n_vec++; if (refScoreAddr !== 15'h1234) begin n_err++; $display("FAIL bright_addr: got %0h want 1234", refScoreAddr); end
        @(negedge clock);
        n_vec++; if (cornerCount !== 16'd1) begin n_err++; $display("FAIL bright_count: got %0d want 1", cornerCount); end
        n_vec++; if (wren !== 1'b0) begin n_err++; $display("FAIL bright_done: wren got %0b want 0", wren); end
    endtask

    task automatic test_dark_wrap;
        run_one(15'h0042, 8'd100, 8'd20, pat(16'hF01F, 8'd60, 8'd100));
        n_vec++; if (wren !== 1'b1) begin n_err++; $display("FAIL dark_wren: got %0b want 1", wren); end
        n_vec++; if (scoreValue !== 8'hB4) begin n_err++; $display("FAIL dark_score: got %0h want b4", scoreValue); end
        n_vec++; if (isCorner !== 1'b1) begin n_err++; $display("FAIL dark_corner: got %0b want 1", isCorner); end
        @(negedge clock);
        n_vec++; if (cornerCount !== 16'd2) begin n_err++; $display("FAIL dark_count: got %0d want 2", cornerCount); end
    endtask

    task automatic test_short_arc;
        int seen;
        seen = 0;
        drive(15'h0077, 8'd100, 8'd20, pat(16'h00FF, 8'd130, 8'd100));
        @(negedge clock);
        inValid = 1'b0;
        if (wren) seen++;
        @(negedge clock);
        if (wren) seen++;
        @(negedge clock);
        if (wren) seen++;
        n_vec++; if (wren_z !== 1'b1) begin n_err++; $display("FAIL short_wz_wren: got %0b want 1", wren_z); end
        n_vec++; if (scoreValue_z !== 8'h00) begin n_err++; $display("FAIL short_wz_score: got %0h want 0", scoreValue_z); end
        n_vec++; if (isCorner_z !== 1'b0) begin n_err++; $display("FAIL short_wz_corner: got %0b want 0", isCorner_z); end
        n_vec++; if (refScoreAddr_z !== 15'h0077) begin n_err++; $display("FAIL short_wz_addr: got %0h want 77", refScoreAddr_z); end
        @(negedge clock);
        if (wren) seen++;
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL short_no_write: wren cycles got %0d want 0", seen); end
        n_vec++; if (cornerCount !== 16'd2) begin n_err++; $display("FAIL short_count: got %0d want 2", cornerCount); end
        n_vec++; if (cornerCount_z !== 16'd2) begin n_err++; $display("FAIL short_wz_count: got %0d want 2", cornerCount_z); end
    endtask

    task automatic test_saturation;
        run_one(15'h7FFF, 8'd0, 8'd0, pat(16'hFFFF, 8'd255, 8'd255));
        n_vec++; if (scoreValue !== 8'hFF) begin n_err++; $display("FAIL sat_score: got %0h want ff", scoreValue); end
        n_vec++; if (isCorner !== 1'b1) begin n_err++; $display("FAIL sat_corner: got %0b want 1", isCorner); end
        @(negedge clock);
        n_vec++; if (cornerCount !== 16'd3) begin n_err++; $display("FAIL sat_count: got %0d want 3", cornerCount); end
    endtask

    task automatic test_back_to_back;
        int idx, got, stall_left, bad_hold, bad_ready;
        bit stall_started;
        logic [ADDR_W+SCORE_W+1:0] held;
        logic [ADDR_W+SCORE_W-1:0] exp_w;
        idx = 0; got = 0; stall_left = 0; stall_started = 0; bad_hold = 0; bad_ready = 0;
        held = '0;
        frameStart = 1'b1;
        @(negedge clock);
        frameStart = 1'b0;
        n_vec++; if (cornerCount !== 16'd0) begin n_err++; $display("FAIL b2b_clear: got %0d want 0", cornerCount); end
        for (int k = 0; k < 4; k++) begin
            exp_w = {ADDR_W'(15'h0100 + k), SCORE_W'(90 + 9 * k)};
            exp_q.push_back(exp_w);
        end
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (wren && !stall_started) begin
                stall_started = 1;
                stall_left    = 5;
                held          = {wren, isCorner, refScoreAddr, scoreValue};
            end
            outReady = (stall_left == 0);
            if (idx < 4) drive(ADDR_W'(15'h0100 + idx), 8'd100, 8'd20,
                               pat(16'h01FF, PIX_W'(130 + idx), 8'd100));
            else inValid = 1'b0;
            #1;
            if (stall_left > 0) begin
                if (inReady !== 1'b0) bad_ready++;
                if ({wren, isCorner, refScoreAddr, scoreValue} !== held) bad_hold++;
                stall_left--;
            end
            if (wren && outReady) begin
                exp_w = exp_q.pop_front();
                n_vec++;
                if ({refScoreAddr, scoreValue} !== exp_w) begin
                    n_err++;
                    $display("FAIL b2b_write%0d: got addr %0h score %0h want addr %0h score %0h",
                             got, refScoreAddr, scoreValue, exp_w[ADDR_W+SCORE_W-1:SCORE_W],
                             exp_w[SCORE_W-1:0]);
                end
                got++;
            end
            if (inValid && inReady) idx++;
            @(negedge clock);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        n_vec++; if (got !== 4) begin n_err++; $display("FAIL b2b_writes: got %0d want 4", got); end
        n_vec++; if (bad_ready !== 0) begin n_err++; $display("FAIL b2b_stall_inready: high cycles %0d want 0", bad_ready); end
        n_vec++; if (bad_hold !== 0) begin n_err++; $display("FAIL b2b_stall_hold: changed cycles %0d want 0", bad_hold); end
        n_vec++; if (cornerCount !== 16'd4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", cornerCount); end
        exp_q.delete();
    endtask

    task automatic test_reset_inflight;
        int seen;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            drive(ADDR_W'(15'h0200 + k), 8'd100, 8'd20, pat(16'h01FF, 8'd130, 8'd100));
            @(negedge clock);
        end
        inValid = 1'b0;
        nReset  = 1'b0;
        #1;
        n_vec++; if (wren !== 1'b0) begin n_err++; $display("FAIL rst_wren: got %0b want 0", wren); end
        n_vec++; if (scoreValue !== '0) begin n_err++; $display("FAIL rst_score: got %0h want 0", scoreValue); end
        n_vec++; if (refScoreAddr !== '0) begin n_err++; $display("FAIL rst_addr: got %0h want 0", refScoreAddr); end
        n_vec++; if (isCorner !== 1'b0) begin n_err++; $display("FAIL rst_corner: got %0b want 0", isCorner); end
        n_vec++; if (cornerCount !== '0) begin n_err++; $display("FAIL rst_count: got %0d want 0", cornerCount); end
        @(negedge clock);
        nReset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (wren || wren_z) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rst_no_write: wren cycles got %0d want 0", seen); end
        n_vec++; if (inReady !== 1'b1) begin n_err++; $display("FAIL rst_inready: got %0b want 1", inReady); end
    endtask

    task automatic test_frame_start;
        run_one(15'h0300, 8'd100, 8'd20, pat(16'h01FF, 8'd130, 8'd100));
        @(negedge clock);
        run_one(15'h0301, 8'd100, 8'd20, pat(16'h01FF, 8'd130, 8'd100));
        @(negedge clock);
        n_vec++; if (cornerCount !== 16'd2) begin n_err++; $display("FAIL fs_pre: got %0d want 2", cornerCount); end
        run_one(15'h0302, 8'd100, 8'd20, pat(16'h01FF, 8'd130, 8'd100));
        frameStart = 1'b1;
        @(negedge clock);
        frameStart = 1'b0;
        n_vec++; if (cornerCount !== 16'd1) begin n_err++; $display("FAIL fs_coincident: got %0d want 1", cornerCount); end
    endtask

    initial begin
        nReset     = 1'b0;
        inValid    = 1'b0;
        refAddr    = '0;
        refPixel   = '0;
        adjPixel   = '0;
        thres      = '0;
        outReady   = 1'b1;
        frameStart = 1'b0;
        test_reset();
        test_bright();
        test_dark_wrap();
        test_short_arc();
        test_saturation();
        test_back_to_back();
        test_reset_inflight();
        test_frame_start();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fs_score_pipe.md
# fs_score_pipe

Parametrised, pipelined FAST corner-score unit with handshaking. Each accepted reference pixel and its Bresenham-circle neighbours are classified against the threshold, and the unit tests for a contiguous circular arc. For every corner it computes a saturated score and issues a write request (`wren`, `refScoreAddr`, `scoreValue`) to the score-memory port, with back-pressure. It sits between the pixel-window fetch logic and the score memory, and replaces the combinational score path, which took external corner and compare inputs.

## Interface
- `PIX_W`, 8: pixel and threshold width.
- `NPTS`, 16: circle points; `adjPixel` holds point i in bits [i*PIX_W +: PIX_W].
- `ARC_LEN`, 9: minimum contiguous same-class points for a corner; legal range 1..NPTS.
- `ADDR_W`, 15: score-memory address width.
- `SCORE_W`, 8: output score width.
- `CNT_W`, 16: corner counter width.
- `WRITE_ZERO`, 0: when 1, non-corners also produce a write, with score 0.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `nReset`, in, 1: asynchronous, active-low reset.
- `inValid`, in, 1: input sample valid.
- `inReady`, out, 1: unit can accept this cycle.
- `refAddr`, in, ADDR_W: reference pixel address.
- `refPixel`, in, PIX_W: reference pixel.
- `adjPixel`, in, NPTS*PIX_W: circle pixels.
- `thres`, in, PIX_W: threshold, sampled with each input.
- `wren`, out, 1: write request valid.
- `outReady`, in, 1: score memory accepts the write.
- `refScoreAddr`, out, ADDR_W: write address (the `refAddr` of that sample).
- `scoreValue`, out, SCORE_W: write data.
- `isCorner`, out, 1: the current write is a corner.
- `frameStart`, in, 1: synchronous clear of `cornerCount`.
- `cornerCount`, out, CNT_W: saturating count of corner writes.

## Operation
- **Classification** (per point i, in PIX_W+1-bit arithmetic, no wrap):
  - bright: adj_i > ref + thres.
  - dark: adj_i + thres < ref.
  - otherwise similar.
- **Excess values:**
  - bright excess e_i = adj_i - ref - thres.
  - dark excess d_i = ref - adj_i - thres.
  - Both are 0 for non-member points.
- **Corner test:** a run of ≥ ARC_LEN consecutive bright points, or of ≥ ARC_LEN consecutive dark points, exists on the circle. The run may wrap from point NPTS-1 to point 0. If every point is bright (or every point is dark), the test passes.
- **Score:**
  - SB = sum of e_i; SD = sum of d_i. Accumulators are PIX_W + clog2(NPTS) bits wide, so they never overflow.
  - raw = max(SB, SD), computed over all points, not just the arc.
  - scoreValue = raw saturated to 2^SCORE_W - 1.
  - For a non-corner: no write when WRITE_ZERO=0; when WRITE_ZERO=1, a write with scoreValue=0 and isCorner=0.
- **Pipeline stages:**
  - S1 registers the classification bits, excesses and address.
  - S2 registers the arc flag, SB and SD.
  - S3 is the output register: wren, refScoreAddr, scoreValue, isCorner.
  - Each stage has a valid bit. Bubbles propagate; they are not collapsed.
- **Flow control:**
  - advance = !S3.valid || outReady.
  - All stages load only when advance is true; otherwise everything holds.
  - inReady = advance.
  - An input is accepted when inValid && inReady.
- **Write handshake:**
  - A write completes on a clock edge where wren && outReady.
  - While outReady is low, wren, refScoreAddr, scoreValue and isCorner hold stable.
- **Counter:**
  - cornerCount increments on each completed write with isCorner=1.
  - It saturates at 2^CNT_W - 1.
  - frameStart has priority. If a corner write completes in the same cycle as frameStart, the result is 1; otherwise the result is 0.
- **Reset:** nReset low clears all valid bits, wren, isCorner, scoreValue, refScoreAddr and cornerCount to 0 immediately. In-flight samples are discarded. inReady = 1 once reset is released (S3 is empty).

## Timing
- Latency: a sample accepted at edge E drives wren high after edge E+2 (three register edges), provided there are no stalls.
- Throughput: one sample per cycle while outReady stays high.
- Each cycle outReady is low while S3 holds valid data adds exactly one cycle to every in-flight sample.
- outReady is ignored while wren is low.
- Stalls never drop or reorder samples. Writes leave in acceptance order.
- thres and refAddr are captured at acceptance; later changes do not affect in-flight samples.

## Test plan
- **Basic bright corner:** ref=100, thres=20, points 0–8 = 130, others = 100. Expected: wren after edge E+2, scoreValue=0x5A (9×10), isCorner=1, refScoreAddr = the input addr.
- **Wrapped dark arc:** points 12–15 and 0–4 = 60, others = 100, thres=20. Expected: corner, scoreValue=0xB4 (9×20).
- **Eight-point arc (just too short):** points 0–7 = 130, others = 100. With WRITE_ZERO=0: no wren, cornerCount unchanged. With WRITE_ZERO=1: one write with scoreValue=0, isCorner=0.
- **Saturation:** ref=0, thres=0, all points = 255. Expected: raw = 4080, scoreValue=0xFF.
- **Back-pressure:** 4 back-to-back corners, outReady held low for 5 cycles from the first wren. Expected: inReady low during the stall, outputs stable, all 4 writes complete in order, cornerCount=4.
- **Reset and counter clear:**
  - nReset asserted with 3 samples in flight: outputs read 0 immediately and no writes occur after release.
  - frameStart coincident with a completing corner write: cornerCount=1.
